vga_sync_monitor: RTL

Receive-side companion to the VGA timing generator: samples the generator's horizontal and vertical sync pulses and recovers pixel and line coordinates from them. Measures line length and frame height, checks them against the expected 800×525 timing, and runs a lock state machine. Downstream logic (overlay, scoreboard capture, self-test) uses it to know where the beam is without tapping the generator's internal counters. One instance sits on the pixel-clock domain next to the VGA output pins.

---
 rtl/vga_sync_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Recovers beam coordinates from the VGA generator's HS/VS pulses, measures
//   line length and frame height, and runs a SEARCH/VERIFY/LOCKED lock FSM
//   against the expected H_TOTAL x V_TOTAL timing.
//
// Ports
//   clk          pixel clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   HS, VS       horizontal / vertical sync from the generator (active high)
//   hcount       recovered pixel index in the current line
//   vcount       recovered line index in the current frame
//   line_len     clocks in the last completed line (saturating at 1023)
//   frame_lines  lines in the last completed frame (saturating at 1023)
//   locked       timing verified and tracking
//   sync_err     one-cycle pulse on a timing violation while locked
//   endofframe   locked and vcount >= V_EOF_START
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_EOF_START = 516
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       HS,
    input  logic       VS,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       sync_err,
    output logic       endofframe
);

    localparam logic [9:0] CNT_MAX = '1;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_EOF   = 10'(V_EOF_START);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } lock_state_t;

    lock_state_t state, state_nxt;

    logic hs_q, hs_p, vs_q, vs_p;
    logic vs_pend;
    logic fault_seen, fault_seen_nxt;
    logic skip_line, skip_line_nxt;
    logic sync_err_nxt;

    logic hs_rise, vs_rise, v_zero;
    logic line_fault, frame_fault, fault;

    // Edge detection and fault qualification on the registered sync samples
    always_comb begin
        hs_rise = hs_q & ~hs_p;
        vs_rise = vs_q & ~vs_p;
        // A pending VS (or one rising together with HS) makes this HS rise
        // the frame origin.
        v_zero  = hs_rise & (vs_pend | vs_rise);
        // The first HS rise after (re)entering SEARCH/VERIFY measures a line
        // of unknown length, so its length check is masked.
        line_fault  = (hs_rise && !skip_line && (hcount != H_LAST))
                    || (hcount == CNT_MAX);
        frame_fault = (v_zero && (vcount != V_LAST))
                    || (vcount == CNT_MAX);
        fault = line_fault | frame_fault;
    end

    // Lock FSM next-state logic
    always_comb begin
        state_nxt      = state;
        fault_seen_nxt = fault_seen;
        skip_line_nxt  = skip_line & ~hs_rise;
        sync_err_nxt   = 1'b0;

        unique case (state)
            SEARCH: begin
                if (v_zero) begin
                    state_nxt      = VERIFY;
                    fault_seen_nxt = 1'b0;
                    skip_line_nxt  = 1'b1;
                end
            end
            VERIFY: begin
                if (v_zero) begin
                    // Faults on the closing HS rise count against this frame
                    if (fault_seen || fault) begin
                        fault_seen_nxt = 1'b0;
                    end else begin
                        state_nxt = LOCKED;
                    end
                end else begin
                    fault_seen_nxt = fault_seen | fault;
                end
            end
            LOCKED: begin
                if (fault) begin
                    state_nxt      = SEARCH;
                    sync_err_nxt   = 1'b1;
                    skip_line_nxt  = 1'b1;
                    fault_seen_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q        <= 1'b0;
            hs_p        <= 1'b0;
            vs_q        <= 1'b0;
            vs_p        <= 1'b0;
            vs_pend     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            state       <= SEARCH;
            fault_seen  <= 1'b0;
            skip_line   <= 1'b1;
            sync_err    <= 1'b0;
        end else begin
            hs_q <= HS;
            hs_p <= hs_q;
            vs_q <= VS;
            vs_p <= vs_q;

            if (hs_rise) begin
                hcount   <= '0;
                line_len <= (hcount == CNT_MAX) ? CNT_MAX : hcount + 10'd1;
            end else if (hcount != CNT_MAX) begin
                hcount <= hcount + 10'd1;
            end

            if (v_zero) begin
                vcount      <= '0;
                frame_lines <= (vcount == CNT_MAX) ? CNT_MAX : vcount + 10'd1;
                vs_pend     <= 1'b0;
            end else begin
                if (hs_rise && (vcount != CNT_MAX)) begin
                    vcount <= vcount + 10'd1;
                end
                if (vs_rise) begin
                    vs_pend <= 1'b1;
                end
            end

            state      <= state_nxt;
            fault_seen <= fault_seen_nxt;
            skip_line  <= skip_line_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

    assign locked     = (state == LOCKED);
    assign endofframe = locked && (vcount >= V_EOF);

endmodule
